// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite types and helpers for the single-master initiator.
// Command struct widths track the default AW/DW of ahb3lite_master.
package ahb3lite_pkg;

  localparam int unsigned AhbAw = 16;
  localparam int unsigned AhbDw = 32;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SizeByte = 3'd0,
    SizeHalf = 3'd1,
    SizeWord = 3'd2
  } hsize_t;

  localparam logic [2:0] HburstSingle = 3'b000;

  typedef enum logic [1:0] {
    KindBus,
    KindLocalErr,
    KindAbort
  } slot_kind_t;

  typedef struct packed {
    logic             write;
    logic [AhbAw-1:0] addr;
    hsize_t           size;
    logic [AhbDw-1:0] wdata;
  } ahb_cmd_t;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return (size > 3'd2) || ((size == 3'd2) && (addr_lo != 2'b00)) ||
           ((size == 3'd1) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/ahb3lite_master.sv
// AHB-Lite single-transfer initiator: valid/ready commands in, pipelined NONSEQ transfers out,
// one in-order response per accepted command.
module ahb3lite_master
  import ahb3lite_pkg::*;
#(
  parameter int unsigned AW        = AhbAw,
  parameter int unsigned DW        = AhbDw,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [2:0]    cmd_size,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_abort,
  output logic          HSEL,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA,
  input  logic          HRESP
);

  // Address slot. r_a_cmd is only rewritten by BUS commands so the bus fields hold otherwise.
  logic       r_a_valid;
  slot_kind_t r_a_kind;
  ahb_cmd_t   r_a_cmd;

  // Data slot; its write data lives directly in the HWDATA register.
  logic          r_d_valid;
  slot_kind_t    r_d_kind;
  logic          r_d_write;
  logic [DW-1:0] r_hwdata;

  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;
  logic          r_rsp_abort;

  logic       w_a_bus;
  logic       w_d_busy;
  logic       w_err_first;
  logic       w_accept;
  slot_kind_t w_new_kind;
  ahb_cmd_t   w_cmd;

  always_comb begin
    w_cmd.write = cmd_write;
    w_cmd.addr  = cmd_addr;
    w_cmd.size  = hsize_t'(cmd_size);
    w_cmd.wdata = cmd_wdata;
  end

  assign w_a_bus     = r_a_valid && (r_a_kind == KindBus);
  assign w_d_busy    = r_d_valid && (r_d_kind == KindBus);
  assign w_err_first = !HREADY && HRESP && w_d_busy;
  assign w_new_kind  = is_misaligned(cmd_size, cmd_addr[1:0]) ? KindLocalErr : KindBus;

  // Hold off during the second ERROR cycle so the queued transfer cannot slip past the abort.
  assign cmd_ready = !r_a_valid || (HREADY && !(HRESP && w_d_busy));
  assign w_accept  = cmd_valid && cmd_ready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_a_valid <= 1'b0;
      r_a_kind  <= KindBus;
      r_a_cmd   <= '0;
      r_d_valid <= 1'b0;
      r_d_kind  <= KindBus;
      r_d_write <= 1'b0;
      r_hwdata  <= '0;
    end else begin
      if (HREADY) begin
        r_d_valid <= r_a_valid;
        r_d_kind  <= r_a_kind;
        r_d_write <= r_a_cmd.write;
        if (w_a_bus && r_a_cmd.write) begin
          r_hwdata <= r_a_cmd.wdata;
        end
      end
      if (w_accept) begin
        r_a_valid <= 1'b1;
        r_a_kind  <= w_new_kind;
        if (w_new_kind == KindBus) begin
          r_a_cmd <= w_cmd;
        end
      end else if (HREADY) begin
        r_a_valid <= 1'b0;
      end else if (w_err_first && w_a_bus) begin
        r_a_kind <= KindAbort;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_abort <= 1'b0;
    end else if (HREADY && r_d_valid) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= (r_d_kind != KindBus) || HRESP;
      r_rsp_abort <= (r_d_kind == KindAbort);
      r_rsp_rdata <= ((r_d_kind == KindBus) && !r_d_write && !HRESP) ? HRDATA : '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_abort <= 1'b0;
    end
  end

  assign HSEL   = w_a_bus;
  assign HTRANS = w_a_bus ? TransNonseq : TransIdle;
  assign HADDR  = r_a_cmd.addr;
  assign HWRITE = r_a_cmd.write;
  assign HSIZE  = r_a_cmd.size;
  assign HBURST = HburstSingle;
  assign HPROT  = HPROT_VAL;
  assign HWDATA = r_hwdata;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign rsp_abort = r_rsp_abort;

endmodule

// File: tb/tb_ahb3lite_master.sv
// Scoreboard bench for ahb3lite_master with a behavioural AHB-Lite slave (waits, ERROR, byte lanes).
module tb_ahb3lite_master;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_abort;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = '0;
  logic        HRESP = 1'b0;

  ahb3lite_master dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_abort (rsp_abort),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        abort;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   last_acc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural slave: decides next-cycle outputs mid-cycle, applies them just after the edge.
  logic        n_ready = 1'b1;
  logic        n_resp = 1'b0;
  logic [31:0] n_rdata = '0;
  logic [31:0] mem [0:63];
  logic        s_valid = 1'b0;
  logic        s_write = 1'b0;
  logic        s_err = 1'b0;
  logic        s_stage = 1'b0;
  logic [15:0] s_addr = '0;
  logic [2:0]  s_size = '0;
  int          s_wait = 0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[13] = 32'h1234_5678;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        s_valid = 1'b0;
        n_ready = 1'b1;
        n_resp  = 1'b0;
        n_rdata = '0;
      end else begin
        if (HREADY) begin
          if (s_valid && s_write && !s_err) begin
            for (int b = 0; b < 4; b++) begin
              logic [1:0] bl;
              bl = 2'(b);
              if ((s_size == 3'd2) || ((s_size == 3'd1) && (bl[1] == s_addr[1])) ||
                  ((s_size == 3'd0) && (bl == s_addr[1:0])))
                mem[s_addr[7:2]][8*b +: 8] = HWDATA[8*b +: 8];
            end
          end
          s_valid = HSEL && (HTRANS == NONSEQ);
          if (s_valid) begin
            s_addr  = HADDR;
            s_write = HWRITE;
            s_size  = HSIZE;
            s_wait  = (HADDR == 16'h0034) ? 3 : 0;
            s_err   = (HADDR == 16'h0020);
            s_stage = 1'b0;
          end
        end
        n_rdata = '0;
        if (s_valid && s_wait > 0) begin
          n_ready = 1'b0; n_resp = 1'b0; s_wait--;
        end else if (s_valid && s_err && !s_stage) begin
          n_ready = 1'b0; n_resp = 1'b1; s_stage = 1'b1;
        end else if (s_valid && s_err) begin
          n_ready = 1'b1; n_resp = 1'b1;
        end else begin
          n_ready = 1'b1; n_resp = 1'b0;
          if (s_valid && !s_write) n_rdata = mem[s_addr[7:2]];
        end
      end
    end
  end

  initial forever begin
    @(posedge HCLK);
    #1;
    HREADY = n_ready;
    HRESP  = n_resp;
    HRDATA = n_rdata;
  end

  // Monitor: bus transfers, wait-state stability and responses against the queues.
  logic        pend_valid = 1'b0;
  logic        pend_write = 1'b0;
  logic [31:0] pend_wdata = '0;
  logic        have_prev = 1'b0;
  logic        prev_hready = 1'b1;
  logic [1:0]  prev_htrans = '0;
  logic [15:0] prev_haddr = '0;
  logic [31:0] prev_hwdata = '0;

  initial forever begin
    @(negedge HCLK);
    if (!HRESETn) begin
      pend_valid = 1'b0;
      have_prev  = 1'b0;
    end else begin
      if (have_prev && !prev_hready) begin
        check("hwdata_stable_in_wait", HWDATA, prev_hwdata);
        if (prev_htrans == NONSEQ) check("haddr_stable_in_wait", HADDR, prev_haddr);
      end
      check("hsel_tracks_nonseq", HSEL, HTRANS == NONSEQ);
      if (HREADY && HRESP) check("idle_in_second_err_cycle", HTRANS, IDLE);
      if (pend_valid && HREADY) begin
        if (pend_write) check("hwdata", HWDATA, pend_wdata);
        pend_valid = 1'b0;
      end
      if (HREADY && HTRANS == NONSEQ) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_nonseq: got HADDR=%0h, required no transfer", HADDR);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          check("haddr", HADDR, b.addr);
          check("hwrite", HWRITE, b.write);
          check("hsize", HSIZE, b.size);
          pend_valid = 1'b1;
          pend_write = b.write;
          pend_wdata = b.wdata;
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got rdata=%0h err=%0b abort=%0b, required no response",
                   rsp_rdata, rsp_err, rsp_abort);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", rsp_err, e.err);
          check("rsp_abort", rsp_abort, e.abort);
          if (e.lat >= 0) check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
      prev_hready = HREADY;
      prev_htrans = HTRANS;
      prev_haddr  = HADDR;
      prev_hwdata = HWDATA;
      have_prev   = 1'b1;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic on_bus, input logic [31:0] e_rdata,
                       input logic e_err, input logic e_abort, input int e_lat);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
    while (!cmd_ready && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    check("cmd_accepted", cmd_ready, 1'b1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    exp_q.push_back('{rdata: e_rdata, err: e_err, abort: e_abort, acc: last_acc, lat: e_lat});
    if (on_bus) bus_q.push_back('{addr: addr, write: wr, size: size, wdata: wdata});
    @(negedge HCLK);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge HCLK);
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 1'b0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    check("queues_drained", 64'(exp_q.size() + bus_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_htrans"}, HTRANS, IDLE);
    check({tag, "_hsel"}, HSEL, 1'b0);
    check({tag, "_haddr"}, HADDR, 16'h0000);
    check({tag, "_hwrite"}, HWRITE, 1'b0);
    check({tag, "_hsize"}, HSIZE, 3'd0);
    check({tag, "_hwdata"}, HWDATA, 32'h0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_rsp_abort"}, rsp_abort, 1'b0);
  endtask

  initial begin
    int a1;
    repeat (3) @(negedge HCLK);
    check_reset_outputs("reset");
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("hburst_single", HBURST, 3'd0);
    check("hprot", HPROT, 4'b0011);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Back-to-back write then read of the same word.
    issue(1'b1, 16'h0010, 3'd2, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0, 2);
    a1 = last_acc;
    issue(1'b0, 16'h0010, 3'd2, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);
    check("b2b_accept_spacing", 64'(last_acc - a1), 64'd1);
    idle(4);

    // Three wait states on the read of 0x0034; a write queued behind it.
    issue(1'b0, 16'h0034, 3'd2, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 5);
    issue(1'b1, 16'h0038, 3'd2, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 1'b0, 5);
    issue(1'b0, 16'h0038, 3'd2, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 2);
    idle(6);

    // Misaligned commands sit between bus neighbours.
    issue(1'b1, 16'h0050, 3'd2, 32'h1111_1111, 1'b1, 32'h0, 1'b0, 1'b0, 2);
    issue(1'b0, 16'h0002, 3'd2, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 2);
    issue(1'b0, 16'h0045, 3'd1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 2);
    issue(1'b0, 16'h0050, 3'd3, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 2);
    issue(1'b0, 16'h0050, 3'd2, 32'h0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 2);
    idle(4);

    // ERROR on write 0x0020 aborts the queued read of 0x0024.
    issue(1'b1, 16'h0020, 3'd2, 32'h0BAD_BAD0, 1'b1, 32'h0, 1'b1, 1'b0, 3);
    issue(1'b0, 16'h0024, 3'd2, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    issue(1'b0, 16'h0010, 3'd2, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 2);
    idle(5);

    // Byte and halfword writes, then a word read to see the merged lanes.
    issue(1'b1, 16'h0041, 3'd0, 32'h0000_AB00, 1'b1, 32'h0, 1'b0, 1'b0, 2);
    issue(1'b1, 16'h0042, 3'd1, 32'hCDEF_0000, 1'b1, 32'h0, 1'b0, 1'b0, 2);
    issue(1'b0, 16'h0040, 3'd2, 32'h0, 1'b1, 32'hCDEF_AB00, 1'b0, 1'b0, 2);
    drain();

    // Reset while a write waits in the data phase and a read holds the address phase.
    issue(1'b1, 16'h0034, 3'd2, 32'h7777_7777, 1'b1, 32'h0, 1'b0, 1'b0, -1);
    issue(1'b0, 16'h0010, 3'd2, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, -1);
    idle(1);
    check("pre_reset_htrans", HTRANS, NONSEQ);
    check("pre_reset_hwdata", HWDATA, 32'h7777_7777);
    #2;
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    idle(8);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb3lite_master.md
# ahb3lite_master

Single-master AHB-Lite initiator that sits directly upstream of the `ahb3liten` slave. It converts a simple valid/ready command stream into pipelined AHB-Lite single transfers, with the address phase of one transfer overlapping the data phase of the previous one. It honours HREADY wait states and two-cycle ERROR responses, and returns one in-order response per accepted command. The slave's HREADYOUT is looped back to HREADY at top level.

## Interface
- `AW`, 16: HADDR and command address width.
- `DW`, 32: data width.
- `HPROT_VAL`, 4'b0011: constant HPROT (non-cacheable, privileged, data).
- `HCLK  in  1`: clock; all state updates on the rising edge.
- `HRESETn  in  1`: reset, asynchronous, active-low.
- `cmd_valid  in  1`: command present.
- `cmd_ready  out  1`: command accepted on an edge where valid && ready.
- `cmd_write  in  1`: 1 = write.
- `cmd_addr  in  AW`: byte address.
- `cmd_size  in  3`: HSIZE encoding; 0, 1 or 2 only.
- `cmd_wdata  in  DW`: write data.
- `rsp_valid  out  1`: one-cycle response pulse; no backpressure.
- `rsp_rdata  out  DW`: captured HRDATA; 0 for writes and errors.
- `rsp_err  out  1`: slave ERROR, local misalignment, or abort.
- `rsp_abort  out  1`: command cancelled by a preceding ERROR and never transferred.
- `HSEL  out  1`, `HADDR  out  AW`, `HTRANS  out  2`, `HWRITE  out  1`, `HSIZE  out  3`, `HBURST  out  3`, `HPROT  out  4`, `HWDATA  out  DW`: AHB master outputs.
- `HREADY  in  1`, `HRDATA  in  DW`, `HRESP  in  1`: AHB slave returns.

## Operation
**Pipeline slots**
- Two slots: address slot A {valid, write, addr, size, wdata, kind} and data slot D {valid, write, wdata, kind}.
- `kind` values: BUS, LOCAL_ERR, ABORT.
- Advance (HREADY=1 at an edge):
  - D ← A (or empty).
  - A ← accepted command (or empty).
  - If D was valid, its response is produced.
- `cmd_ready` = !A.valid || (HREADY && !(HRESP && d_busy)).

**Address phase outputs**
- With A.valid && A.kind==BUS: HTRANS=NONSEQ, HSEL=1, HADDR/HWRITE/HSIZE taken from A.
- Otherwise: HTRANS=IDLE and HSEL=0. HADDR/HWRITE/HSIZE hold their last value.
- HBURST is always SINGLE (0). HPROT is always HPROT_VAL.

**Data phase**
- HWDATA = D.wdata while D.valid && D.write; otherwise it holds.
- HWDATA is stable through wait states.

**Misalignment**
- A command with size>2, size==2 && addr[1:0]!=0, or size==1 && addr[0] gets kind=LOCAL_ERR.
- It takes a pipeline slot but never drives NONSEQ, which preserves response order.

**ERROR handling**
- First error cycle is HREADY=0, HRESP=1 with D.kind==BUS.
- At that edge, if A.valid && A.kind==BUS, A.kind becomes ABORT, so HTRANS=IDLE in the second error cycle.
- The aborted command later responds with err=1, abort=1.

**Response**
- Registered, one cycle after the D-completing edge.
- rdata = HRDATA sampled at completion, for BUS reads with HRESP=0.

## Timing
- **Reset values:** HTRANS=IDLE, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_abort=0.
- **Reset effect:** both slots are emptied asynchronously. Reset mid-transfer discards in-flight commands with no response.
- **Zero-wait latency:** command accepted at edge N → NONSEQ in cycle N..N+1 → data phase cycle N+1..N+2 → rsp_valid high in cycle after edge N+2.
- **Throughput:** one transfer per cycle.
- **Wait states:** each HREADY=0 cycle stalls both slots and delays the response by one cycle. cmd_ready stays 1 only while A is empty.
- **Simultaneous events:** acceptance and completion on the same edge are legal. A LOCAL_ERR entry in D completes when HREADY=1.

## Structure
- Shared package `ahb3lite_pkg` holds:
  - `htrans_t` (IDLE/BUSY/NONSEQ/SEQ), `hsize_t`, and HBURST SINGLE constant;
  - slot kind enum;
  - `ahb_cmd_t` struct (write, addr, size, wdata).
- Single module, no sub-module. The alignment check is a package function `is_misaligned`.

## Test plan
- **Reset:** HRESETn=0 mid-stream → outputs at reset values asynchronously; no rsp_valid after release.
- **Back-to-back:** write 0x0010 = 0xDEADBEEF then read 0x0010, zero waits → NONSEQ on consecutive cycles; HWDATA=0xDEADBEEF in cycle 2; two rsp pulses, rdata=0xDEADBEEF.
- **Wait states:** slave holds HREADY=0 for 3 cycles on a read → HADDR and HWDATA stable; rsp 3 cycles later; next NONSEQ held.
- **Misaligned:** word read at 0x0002 → HTRANS stays IDLE; rsp_err=1, rsp_abort=0, in order between neighbours.
- **ERROR:** ERROR on write to 0x0020 with a read 0x0024 queued → HTRANS=IDLE in the second error cycle; rsp err=1, then rsp err=1 abort=1.
- **Byte/halfword:** writes to 0x0041 (size 0) and 0x0042 (size 1) → HSIZE 0/1 on the bus; responses err=0.
